// File: rtl/fpsqrt_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fpsqrt_rr_scheduler
//
// Shares one fixed-latency pipelined FloPoCo single-precision square-root
// unit between NUM_REQ requesters. Operands are issued round-robin. A tag
// pipeline of {valid, id} runs alongside the sqrt datapath, so each result
// is routed back to the requester that issued it. If the result at the
// pipeline head cannot be delivered, the sqrt clock-enable is dropped and
// the whole pipeline (datapath and tags) freezes.
//
// Operand format (34 bits): exn[33:32], sign[31], exp[30:23], mant[22:0].
// The operand contents are never inspected here.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]      per-requester operand valid
//   req_ready  out  [NUM_REQ]      operand accepted this cycle (one-hot or 0)
//   req_x      in   [34*NUM_REQ]   operands, requester i at [34*i+33:34*i]
//   res_valid  out  [NUM_REQ]      result valid for requester i (one-hot or 0)
//   res_ready  in   [NUM_REQ]      requester i accepts its result
//   res_r      out  [34]           result word, shared by all requesters
//   sq_ce      out                 clock-enable to the sqrt pipeline
//   sq_x       out  [34]           operand to the sqrt pipeline
//   sq_r       in   [34]           sqrt pipeline result (pairs with the head)
//   inflight   out                 number of valid tags in the pipeline
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. req_ready may depend combinationally on req_valid; req_valid must
// not depend on req_ready. res_valid depends only on registered tag state;
// res_ready feeds sq_ce combinationally.
// ---------------------------------------------------------------------------
module fpsqrt_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_STAGES = 8,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [34*NUM_REQ-1:0]           req_x,
  output logic [NUM_REQ-1:0]              res_valid,
  input  logic [NUM_REQ-1:0]              res_ready,
  output logic [33:0]                     res_r,
  output logic                            sq_ce,
  output logic [33:0]                     sq_x,
  input  logic [33:0]                     sq_r,
  output logic [$clog2(NUM_STAGES+1):0]   inflight
);

  localparam int CNT_W = $clog2(NUM_STAGES + 1) + 1;

  // Registered state
  logic [ID_W-1:0]       r_ptr;
  logic [NUM_STAGES-1:0] r_tag_v;
  logic [ID_W-1:0]       r_tag_id [NUM_STAGES];
  logic [CNT_W-1:0]      r_inflight;

  // Combinational signals
  logic            w_head_v;
  logic [ID_W-1:0] w_head_id;
  logic            w_head_rdy;
  logic            w_xfer;
  logic            w_any;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_issue;

  // Head of the tag pipeline pairs with sq_r.
  assign w_head_v   = r_tag_v[NUM_STAGES-1];
  assign w_head_id  = r_tag_id[NUM_STAGES-1];
  assign w_head_rdy = res_ready[w_head_id];
  assign w_xfer     = w_head_v && w_head_rdy;

  // Stall only when an undeliverable result sits at the head.
  assign sq_ce = !(w_head_v && !w_head_rdy);

  // Round-robin scan starting at r_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any && req_valid[idx]) begin
        w_any    = 1'b1;
        w_gnt_id = ID_W'(idx);
      end
    end
  end

  // rst_n gates issue so no operand is reported accepted while the tag
  // pipeline is held in reset.
  assign w_issue = w_any && sq_ce && rst_n;

  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_gnt_id] = 1'b1;
  end

  // With no request the operand is a zero bubble (stage 0 tag invalid).
  assign sq_x = w_any ? req_x[int'(w_gnt_id)*34 +: 34] : 34'b0;

  always_comb begin
    res_valid = '0;
    if (w_head_v) res_valid[w_head_id] = 1'b1;
  end

  assign res_r    = sq_r;
  assign inflight = r_inflight;

  // Tag pipeline, pointer and occupancy all advance only with sq_ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_tag_v    <= '0;
      r_inflight <= '0;
      for (int s = 0; s < NUM_STAGES; s++) r_tag_id[s] <= '0;
    end else if (sq_ce) begin
      for (int s = 1; s < NUM_STAGES; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_gnt_id;

      if (w_issue) begin
        if (w_gnt_id == ID_W'(NUM_REQ - 1)) r_ptr <= '0;
        else                                r_ptr <= w_gnt_id + ID_W'(1);
      end

      // Simultaneous issue and delivery leaves the count unchanged.
      case ({w_issue, w_xfer})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule
